// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pong_game_ctrl
// Description : Pong game sequencer: state, scores, serve delay, ball recentre.
// Revision    : 1.0 - initial release
// ============================================================================
module pong_game_ctrl #(
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_FRAMES = 60,
    parameter int OVER_FRAMES  = 300,
    parameter int CNT_W        = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_btn,
    input  logic       frame_tick,
    input  logic       point_p1,
    input  logic       point_p2,
    output logic [1:0] state,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic       ball_reset,
    output logic       serve_dir,
    output logic [1:0] winner
);

    typedef enum logic [1:0] {
        ST_PLAY  = 2'b00,
        ST_TITLE = 2'b01,
        ST_SERVE = 2'b10,
        ST_OVER  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] c_serve_last = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [CNT_W-1:0] c_over_last  = CNT_W'(OVER_FRAMES - 1);
    localparam logic [3:0]       c_win        = 4'(WIN_SCORE);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       score1_q, score1_d, score2_q, score2_d;
    logic [1:0]       winner_q, winner_d;
    logic             ball_reset_q, ball_reset_d;
    logic             serve_dir_q, serve_dir_d;
    logic             start_meta_q, start_sync_q, start_prev_q;
    logic             p1_prev_q, p2_prev_q;

    logic             start_pulse, p1_edge, p2_edge;
    logic [3:0]       score1_inc, score2_inc;

    assign start_pulse = start_sync_q & ~start_prev_q;
    assign p1_edge     = point_p1 & ~p1_prev_q;
    assign p2_edge     = point_p2 & ~p2_prev_q;
    assign score1_inc  = score1_q + 4'd1;
    assign score2_inc  = score2_q + 4'd1;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        score1_d     = score1_q;
        score2_d     = score2_q;
        winner_d     = winner_q;
        serve_dir_d  = serve_dir_q;
        ball_reset_d = 1'b0;
        case (state_q)
            ST_TITLE: begin
                if (start_pulse) begin
                    state_d      = ST_SERVE;
                    cnt_d        = '0;
                    score1_d     = 4'd0;
                    score2_d     = 4'd0;
                    winner_d     = 2'b00;
                    ball_reset_d = 1'b1;
                end
            end
            ST_SERVE: begin
                if (frame_tick) begin
                    if (cnt_q == c_serve_last) begin
                        state_d = ST_PLAY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_PLAY: begin
                // P1 has priority when both walls are hit in the same cycle.
                if (p1_edge) begin
                    score1_d    = score1_inc;
                    serve_dir_d = 1'b0;
                    cnt_d       = '0;
                    if (score1_inc == c_win) begin
                        state_d  = ST_OVER;
                        winner_d = 2'b01;
                    end else begin
                        state_d      = ST_SERVE;
                        ball_reset_d = 1'b1;
                    end
                end else if (p2_edge) begin
                    score2_d    = score2_inc;
                    serve_dir_d = 1'b1;
                    cnt_d       = '0;
                    if (score2_inc == c_win) begin
                        state_d  = ST_OVER;
                        winner_d = 2'b10;
                    end else begin
                        state_d      = ST_SERVE;
                        ball_reset_d = 1'b1;
                    end
                end
            end
            ST_OVER: begin
                if (start_pulse) begin
                    state_d = ST_TITLE;
                    cnt_d   = '0;
                end else if (frame_tick) begin
                    if (cnt_q == c_over_last) begin
                        state_d = ST_TITLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_TITLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_TITLE;
            cnt_q        <= '0;
            score1_q     <= 4'd0;
            score2_q     <= 4'd0;
            winner_q     <= 2'b00;
            ball_reset_q <= 1'b0;
            serve_dir_q  <= 1'b0;
            start_meta_q <= 1'b0;
            start_sync_q <= 1'b0;
            start_prev_q <= 1'b0;
            p1_prev_q    <= 1'b0;
            p2_prev_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            score1_q     <= score1_d;
            score2_q     <= score2_d;
            winner_q     <= winner_d;
            ball_reset_q <= ball_reset_d;
            serve_dir_q  <= serve_dir_d;
            start_meta_q <= start_btn;
            start_sync_q <= start_meta_q;
            start_prev_q <= start_sync_q;
            p1_prev_q    <= point_p1;
            p2_prev_q    <= point_p2;
        end
    end

    assign state      = state_q;
    assign score1     = score1_q;
    assign score2     = score2_q;
    assign winner     = winner_q;
    assign ball_reset = ball_reset_q;
    assign serve_dir  = serve_dir_q;

endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pong_game_ctrl
// Description : Scenario tests plus randomized run against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pong_game_ctrl;

    localparam int SF = 60;
    localparam int OF = 300;
    localparam int WS = 9;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start_btn = 1'b0;
    logic       frame_tick = 1'b0;
    logic       point_p1 = 1'b0;
    logic       point_p2 = 1'b0;
    logic [1:0] state;
    logic [3:0] score1, score2;
    logic       ball_reset, serve_dir;
    logic [1:0] winner;

    int checks = 0;
    int errors = 0;

    // behavioural model: game rules in plain integers
    int m_state = 1, m_s1 = 0, m_s2 = 0, m_win = 0, m_ticks = 0;
    bit m_br = 0, m_dir = 0;
    bit h1 = 0, h2 = 0, h3 = 0;   // raw start_btn seen 1, 2, 3 edges ago
    bit m_p1p = 0, m_p2p = 0;

    pong_game_ctrl #(.WIN_SCORE(WS), .SERVE_FRAMES(SF), .OVER_FRAMES(OF), .CNT_W(9)) dut (
        .clk(clk), .reset(reset), .start_btn(start_btn), .frame_tick(frame_tick),
        .point_p1(point_p1), .point_p2(point_p2), .state(state), .score1(score1),
        .score2(score2), .ball_reset(ball_reset), .serve_dir(serve_dir), .winner(winner)
    );

    always #5 clk = ~clk;

    task automatic model_update();
        bit sp, e1, e2;
        sp = h2 && !h3;
        e1 = point_p1 && !m_p1p;
        e2 = point_p2 && !m_p2p;
        if (!reset) begin
            m_state = 1; m_s1 = 0; m_s2 = 0; m_win = 0; m_ticks = 0;
            m_br = 0; m_dir = 0; h1 = 0; h2 = 0; h3 = 0; m_p1p = 0; m_p2p = 0;
            return;
        end
        h3 = h2; h2 = h1; h1 = start_btn;
        m_p1p = point_p1; m_p2p = point_p2;
        m_br = 0;
        case (m_state)
            1: if (sp) begin
                m_state = 2; m_s1 = 0; m_s2 = 0; m_win = 0; m_ticks = 0; m_br = 1;
            end
            2: if (frame_tick) begin
                m_ticks++;
                if (m_ticks == SF) begin m_state = 0; m_ticks = 0; end
            end
            0: if (e1 || e2) begin
                if (e1) begin m_s1++; m_dir = 0; end
                else begin m_s2++; m_dir = 1; end
                m_ticks = 0;
                if (m_s1 == WS || m_s2 == WS) begin
                    m_state = 3; m_win = (m_s1 == WS) ? 1 : 2;
                end else begin
                    m_state = 2; m_br = 1;
                end
            end
            default: begin
                if (sp) begin m_state = 1; m_ticks = 0; end
                else if (frame_tick) begin
                    m_ticks++;
                    if (m_ticks == OF) begin m_state = 1; m_ticks = 0; end
                end
            end
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic serve_wait();
        frame_tick = 1'b1;
        repeat (SF) step();
        frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step(); step();
        checks++;
        if ({state, score1, score2, winner, ball_reset, serve_dir} !== {2'b01, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: got st=%b s1=%0d s2=%0d w=%b br=%b dir=%b, want 01/0/0/00/0/0",
                     state, score1, score2, winner, ball_reset, serve_dir);
        end
        reset = 1'b1;
        step();
        checks++;
        if (state !== 2'b01) begin errors++; $display("FAIL reset_release: state=%b want 01", state); end
    endtask

    task automatic test_start_serve();
        int br_cnt = 0;
        int n = 0;
        start_btn = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (ball_reset) br_cnt++;
            if (i == 2) begin
                checks++;
                if (state !== 2'b01) begin errors++; $display("FAIL start_edge2: state=%b want 01", state); end
            end
            if (i == 3) begin
                checks++;
                if (state !== 2'b10) begin errors++; $display("FAIL start_edge3: state=%b want 10", state); end
            end
        end
        start_btn = 1'b0;
        checks++;
        if (br_cnt != 1) begin errors++; $display("FAIL start_one_pulse: ball_reset pulses=%0d want 1", br_cnt); end
        checks++;
        if (state !== 2'b10) begin errors++; $display("FAIL serve_no_tick: state=%b want 10", state); end
        frame_tick = 1'b1;
        while (state !== 2'b00 && n < 200) begin step(); n++; end
        frame_tick = 1'b0;
        checks++;
        if (n != SF) begin errors++; $display("FAIL serve_length: ticks=%0d want %0d", n, SF); end
    endtask

    task automatic test_point_hold();
        int br_cnt = 0;
        point_p1 = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            step();
            if (ball_reset) br_cnt++;
        end
        point_p1 = 1'b0;
        step();
        checks++;
        if ({score1, score2, serve_dir, state} !== {4'd1, 4'd0, 1'b0, 2'b10}) begin
            errors++;
            $display("FAIL point_hold: s1=%0d s2=%0d dir=%b st=%b want 1/0/0/10", score1, score2, serve_dir, state);
        end
        checks++;
        if (br_cnt != 1) begin errors++; $display("FAIL point_hold_br: pulses=%0d want 1", br_cnt); end
        serve_wait();
    endtask

    task automatic test_simultaneous();
        point_p1 = 1'b1; point_p2 = 1'b1;
        step();
        point_p1 = 1'b0; point_p2 = 1'b0;
        checks++;
        if ({score1, score2, serve_dir, state} !== {4'd2, 4'd0, 1'b0, 2'b10}) begin
            errors++;
            $display("FAIL simultaneous: s1=%0d s2=%0d dir=%b st=%b want 2/0/0/10", score1, score2, serve_dir, state);
        end
        step();
        serve_wait();
    endtask

    task automatic test_win();
        int n = 0;
        for (int k = 0; k < 8; k++) begin
            point_p2 = 1'b1; step();
            point_p2 = 1'b0; step();
            serve_wait();
        end
        checks++;
        if ({score2, state, serve_dir} !== {4'd8, 2'b00, 1'b1}) begin
            errors++; $display("FAIL p2_eight: s2=%0d st=%b dir=%b want 8/00/1", score2, state, serve_dir);
        end
        point_p2 = 1'b1; step();
        point_p2 = 1'b0;
        checks++;
        if ({score1, score2, state, winner, ball_reset} !== {4'd2, 4'd9, 2'b11, 2'b10, 1'b0}) begin
            errors++;
            $display("FAIL p2_win: s1=%0d s2=%0d st=%b w=%b br=%b want 2/9/11/10/0",
                     score1, score2, state, winner, ball_reset);
        end
        step();
        point_p1 = 1'b1; step();
        point_p1 = 1'b0; step();
        checks++;
        if ({score1, score2, state, ball_reset} !== {4'd2, 4'd9, 2'b11, 1'b0}) begin
            errors++; $display("FAIL over_hold: s1=%0d s2=%0d st=%b br=%b want 2/9/11/0", score1, score2, state, ball_reset);
        end
        frame_tick = 1'b1;
        while (state !== 2'b01 && n < 400) begin step(); n++; end
        frame_tick = 1'b0;
        checks++;
        if (n != OF) begin errors++; $display("FAIL over_length: ticks=%0d want %0d", n, OF); end
        checks++;
        if ({score1, score2, winner} !== {4'd2, 4'd9, 2'b10}) begin
            errors++; $display("FAIL title_scores: s1=%0d s2=%0d w=%b want 2/9/10", score1, score2, winner);
        end
    endtask

    task automatic test_ignored_and_reset_mid_serve();
        point_p1 = 1'b1; point_p2 = 1'b1; step();
        point_p1 = 1'b0; point_p2 = 1'b0; step();
        checks++;
        if ({score1, score2, state} !== {4'd2, 4'd9, 2'b01}) begin
            errors++; $display("FAIL title_points: s1=%0d s2=%0d st=%b want 2/9/01", score1, score2, state);
        end
        start_btn = 1'b1; step(); step(); step();
        start_btn = 1'b0;
        checks++;
        if ({score1, score2, winner, state, ball_reset} !== {4'd0, 4'd0, 2'b00, 2'b10, 1'b1}) begin
            errors++;
            $display("FAIL restart: s1=%0d s2=%0d w=%b st=%b br=%b want 0/0/00/10/1",
                     score1, score2, winner, state, ball_reset);
        end
        point_p2 = 1'b1; step();
        point_p2 = 1'b0; step();
        checks++;
        if ({score1, score2, serve_dir} !== {4'd0, 4'd0, 1'b1}) begin
            errors++; $display("FAIL serve_points: s1=%0d s2=%0d dir=%b want 0/0/1", score1, score2, serve_dir);
        end
        frame_tick = 1'b1; repeat (30) step(); frame_tick = 1'b0;
        reset = 1'b0; step();
        checks++;
        if ({state, score1, score2, winner, serve_dir} !== {2'b01, 4'd0, 4'd0, 2'b00, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_serve: st=%b s1=%0d s2=%0d w=%b dir=%b want 01/0/0/00/0",
                     state, score1, score2, winner, serve_dir);
        end
        reset = 1'b1; step();
    endtask

    task automatic test_random();
        bit prev_br = 1'b0;
        for (int i = 0; i < 12000; i++) begin
            reset      = ($urandom_range(0, 3999) != 0);
            if ($urandom_range(0, 39) == 0) start_btn = ~start_btn;
            frame_tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 5) == 0) point_p1 = ~point_p1;
            if ($urandom_range(0, 5) == 0) point_p2 = ~point_p2;
            step();
            checks++;
            if ({state, score1, score2, winner, ball_reset, serve_dir} !==
                {2'(m_state), 4'(m_s1), 4'(m_s2), 2'(m_win), m_br, m_dir}) begin
                errors++;
                if (errors < 20)
                    $display("FAIL random_model cyc %0d: got st=%b s1=%0d s2=%0d w=%b br=%b dir=%b want st=%0d s1=%0d s2=%0d w=%0d br=%b dir=%b",
                             i, state, score1, score2, winner, ball_reset, serve_dir,
                             m_state, m_s1, m_s2, m_win, m_br, m_dir);
            end
            checks++;
            if (ball_reset && prev_br) begin
                errors++;
                if (errors < 20) $display("FAIL ball_reset_double cyc %0d: got 1,1 want never two in a row", i);
            end
            prev_br = ball_reset;
        end
        start_btn = 1'b0; point_p1 = 1'b0; point_p2 = 1'b0; frame_tick = 1'b0; reset = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_start_serve();
        test_point_hold();
        test_simultaneous();
        test_win();
        test_ignored_and_reset_mid_serve();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
